// File: rtl/block_gen_pkg.sv
// rtl/block_gen_pkg.sv - opcodes, ASCII constants, FSM encoding and keyword lengths for the block stream generator
package block_gen_pkg;

  typedef enum logic [1:0] {
    OP_BEGIN = 2'b00,
    OP_END   = 2'b01,
    OP_CHAR  = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  // Emitted byte counts, including the trailing space of each keyword
  localparam logic [2:0] LEN_BEGIN = 3'd6;
  localparam logic [2:0] LEN_END   = 3'd4;
  localparam logic [2:0] LEN_CHAR  = 3'd1;

  // Number of bytes a command emits; NOP emits nothing
  function automatic logic [2:0] op_len(op_e op);
    case (op)
      OP_BEGIN: op_len = LEN_BEGIN;
      OP_END:   op_len = LEN_END;
      OP_CHAR:  op_len = LEN_CHAR;
      default:  op_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/block_stream_gen_if.sv
// rtl/block_stream_gen_if.sv - command, character stream and nesting status bundle
interface block_stream_gen_if #(
  parameter int DEPTH_W = 5
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [7:0]         cmd_char;
  logic [4:0]         cmd_upper;
  logic [7:0]         out;
  logic               out_valid;
  logic [DEPTH_W-1:0] depth;
  logic               balanced;
  logic               underflow;
  logic               overflow;

  modport master (
    output cmd_valid, cmd_op, cmd_char, cmd_upper,
    input  cmd_ready, out, out_valid, depth, balanced, underflow, overflow
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_char, cmd_upper,
    output cmd_ready, out, out_valid, depth, balanced, underflow, overflow
  );

endinterface

// File: rtl/block_char_rom.sv
// rtl/block_char_rom.sv - byte lookup for each position of a BEGIN/END keyword or CHAR literal
module block_char_rom
  import block_gen_pkg::*;
(
  input  op_e        op,
  input  logic [2:0] idx,
  input  logic [4:0] mask,
  input  logic [7:0] lit,
  output logic [7:0] char
);

  logic [7:0] w_lower;
  logic [7:0] w_mask_ext;
  logic       w_is_letter;

  // Widen the mask so any 3-bit index selects in range
  assign w_mask_ext  = {3'b000, mask};
  // Only keyword letters take the mask; the trailing space and literals never do
  assign w_is_letter = ((op == OP_BEGIN) || (op == OP_END)) && (idx < (op_len(op) - 3'd1));

  // Lowercase byte for the current position; anything past a word is a space
  always_comb begin
    w_lower = ASCII_SPACE;
    case (op)
      OP_BEGIN: begin
        case (idx)
          3'd0:    w_lower = 8'h62;
          3'd1:    w_lower = 8'h65;
          3'd2:    w_lower = 8'h67;
          3'd3:    w_lower = 8'h69;
          3'd4:    w_lower = 8'h6E;
          default: w_lower = ASCII_SPACE;
        endcase
      end
      OP_END: begin
        case (idx)
          3'd0:    w_lower = 8'h65;
          3'd1:    w_lower = 8'h6E;
          3'd2:    w_lower = 8'h64;
          default: w_lower = ASCII_SPACE;
        endcase
      end
      OP_CHAR: w_lower = lit;
      default: w_lower = ASCII_SPACE;
    endcase
  end

  assign char = (w_is_letter && w_mask_ext[idx]) ? (w_lower - CASE_OFFSET) : w_lower;

endmodule

// File: rtl/block_stream_gen.sv
// rtl/block_stream_gen.sv - emits "begin "/"end "/literal bytes and tracks block nesting depth
module block_stream_gen
  import block_gen_pkg::*;
#(
  parameter int DEPTH_W = 5
) (
  input logic               clk,
  input logic               reset,
  block_stream_gen_if.slave bus
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};

  state_e             r_state;
  logic [2:0]         r_idx;
  op_e                r_op;
  logic [7:0]         r_char;
  logic [4:0]         r_upper;
  logic [7:0]         r_out;
  logic               r_out_valid;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_underflow;
  logic               r_overflow;

  op_e        w_cmd_op;
  logic       w_last;
  logic       w_ready;
  logic       w_accept;
  logic [7:0] w_rom_char;

  assign w_cmd_op = op_e'(bus.cmd_op);
  // Ready on the last byte of a word lets the next command follow with no gap
  assign w_last   = (r_state == ST_EMIT) && (r_idx == (op_len(r_op) - 3'd1));
  assign w_ready  = (r_state == ST_IDLE) || w_last;
  assign w_accept = bus.cmd_valid && w_ready;

  block_char_rom u_rom (
    .op   (r_op),
    .idx  (r_idx),
    .mask (r_upper),
    .lit  (r_char),
    .char (w_rom_char)
  );

  // Sequencer: accept commands, walk the byte index and register the outgoing byte
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= 3'd0;
      r_op        <= OP_NOP;
      r_char      <= 8'h00;
      r_upper     <= 5'b00000;
      r_out       <= ASCII_SPACE;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (r_state == ST_EMIT);
      r_out       <= (r_state == ST_EMIT) ? w_rom_char : ASCII_SPACE;
      if (w_accept && (w_cmd_op != OP_NOP)) begin
        r_state <= ST_EMIT;
        r_idx   <= 3'd0;
        r_op    <= w_cmd_op;
        r_char  <= bus.cmd_char;
        r_upper <= bus.cmd_upper;
      end else if (w_last) begin
        r_state <= ST_IDLE;
        r_idx   <= 3'd0;
      end else if (r_state == ST_EMIT) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  // Nesting depth with sticky error flags; moves on the accept edge, saturating both ways
  always_ff @(posedge clk) begin
    if (reset) begin
      r_depth     <= '0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_accept) begin
      if (w_cmd_op == OP_BEGIN) begin
        if (r_depth == DEPTH_MAX) begin
          r_overflow <= 1'b1;
        end else begin
          r_depth <= r_depth + 1'b1;
        end
      end else if (w_cmd_op == OP_END) begin
        if (r_depth == '0) begin
          r_underflow <= 1'b1;
        end else begin
          r_depth <= r_depth - 1'b1;
        end
      end
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.depth     = r_depth;
  assign bus.balanced  = (r_depth == '0) && !r_underflow;
  assign bus.underflow = r_underflow;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_block_stream_gen.sv
// tb/tb_block_stream_gen.sv - self-checking bench for block_stream_gen at DEPTH_W 5 and 2
module tb_block_stream_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_char;
  logic [4:0] cmd_upper;

  int checks = 0;
  int failures = 0;

  // Reference model: bytes still to appear, depth and flags for both widths
  logic [7:0] q[$];
  int         dep_a, dep_b;
  bit         uf_a, uf_b, of_a, of_b;
  logic [7:0] exp_out;
  logic       exp_valid;
  bit         m_ready, m_accept;
  logic       obs_ready_a, obs_ready_b;

  // Independent block checker fed from the DUT character stream
  logic [39:0] ck_word;
  int          ck_len, ck_dep;
  bit          ck_uf;

  always #5 clk = ~clk;

  block_stream_gen_if #(.DEPTH_W(5)) bus_a ();
  block_stream_gen_if #(.DEPTH_W(2)) bus_b ();

  assign bus_a.cmd_valid = cmd_valid;
  assign bus_a.cmd_op    = cmd_op;
  assign bus_a.cmd_char  = cmd_char;
  assign bus_a.cmd_upper = cmd_upper;
  assign bus_b.cmd_valid = cmd_valid;
  assign bus_b.cmd_op    = cmd_op;
  assign bus_b.cmd_char  = cmd_char;
  assign bus_b.cmd_upper = cmd_upper;

  block_stream_gen #(.DEPTH_W(5)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  block_stream_gen #(.DEPTH_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // One clock: drive at the falling edge, advance the model at the rising edge, return at the next falling edge
  task automatic step(input bit rst, input bit v, input logic [1:0] op, input logic [7:0] ch, input logic [4:0] up);
    string      s;
    logic [7:0] b;
    obs_ready_a = bus_a.cmd_ready;
    obs_ready_b = bus_b.cmd_ready;
    m_ready     = (q.size() <= 1);
    m_accept    = !rst && v && m_ready;
    reset = rst; cmd_valid = v; cmd_op = op; cmd_char = ch; cmd_upper = up;
    @(posedge clk);
    if (rst) begin
      q.delete();
      dep_a = 0; dep_b = 0; uf_a = 0; uf_b = 0; of_a = 0; of_b = 0;
      exp_out = 8'h20; exp_valid = 1'b0;
    end else begin
      if (q.size() > 0) begin
        exp_out = q.pop_front(); exp_valid = 1'b1;
      end else begin
        exp_out = 8'h20; exp_valid = 1'b0;
      end
      if (m_accept) begin
        s = "";
        case (op)
          2'b00: begin
            s = "begin ";
            if (dep_a == 31) of_a = 1; else dep_a++;
            if (dep_b == 3) of_b = 1; else dep_b++;
          end
          2'b01: begin
            s = "end ";
            if (dep_a == 0) uf_a = 1; else dep_a--;
            if (dep_b == 0) uf_b = 1; else dep_b--;
          end
          2'b10: q.push_back(ch);
          default: s = "";
        endcase
        for (int i = 0; i < s.len(); i++) begin
          b = s[i];
          if (i < s.len() - 1 && up[i]) b = b - 8'h20;
          q.push_back(b);
        end
      end
    end
    @(negedge clk);
    if (rst) begin
      ck_word = '0; ck_len = 0; ck_dep = 0; ck_uf = 0;
    end else if (bus_a.out_valid === 1'b1) begin
      b = bus_a.out;
      if (b == 8'h20) begin
        if (ck_len == 5 && ck_word == "begin") ck_dep++;
        else if (ck_len == 3 && ck_word[23:0] == "end") begin
          if (ck_dep == 0) ck_uf = 1; else ck_dep--;
        end
        ck_word = '0; ck_len = 0;
      end else begin
        if (b >= 8'h41 && b <= 8'h5A) b = b + 8'h20;
        ck_word = {ck_word[31:0], b}; ck_len++;
      end
    end
  endtask

  task automatic test_reset();
    step(1, 0, 2'b00, 8'h00, 5'b0);
    step(1, 1, 2'b00, 8'h00, 5'b0);
    checks++; if (bus_a.out !== 8'h20) begin failures++; $display("FAIL reset_out act=%h exp=20", bus_a.out); end
    checks++; if (bus_a.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid act=%b exp=0", bus_a.out_valid); end
    checks++; if (bus_a.depth !== 5'd0 || bus_b.depth !== 2'd0) begin failures++; $display("FAIL reset_depth act=%0d/%0d exp=0/0", bus_a.depth, bus_b.depth); end
    checks++; if (bus_a.underflow !== 1'b0 || bus_a.overflow !== 1'b0) begin failures++; $display("FAIL reset_flags act=%b%b exp=00", bus_a.underflow, bus_a.overflow); end
    step(0, 0, 2'b00, 8'h00, 5'b0);
    checks++; if (bus_a.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready act=%b exp=1", bus_a.cmd_ready); end
    checks++; if (bus_a.balanced !== 1'b1) begin failures++; $display("FAIL reset_balanced act=%b exp=1", bus_a.balanced); end
    step(0, 0, 2'b00, 8'h00, 5'b0);
    checks++; if (bus_a.out_valid !== 1'b0 || bus_a.depth !== 5'd0) begin failures++; $display("FAIL reset_ignored_cmd act=%b/%0d exp=0/0", bus_a.out_valid, bus_a.depth); end
  endtask

  task automatic test_single_begin();
    logic [47:0] exp = 48'h626567696E20;
    step(1, 0, 2'b00, 8'h00, 5'b0);
    step(0, 1, 2'b00, 8'h00, 5'b00000);
    checks++; if (bus_a.out_valid !== 1'b0) begin failures++; $display("FAIL begin_latency act=%b exp=0", bus_a.out_valid); end
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 2'b00, 8'h00, 5'b0);
      checks++;
      if (bus_a.out !== exp[47-8*k -: 8] || bus_a.out_valid !== 1'b1) begin
        failures++; $display("FAIL begin_byte%0d act=%h/%b exp=%h/1", k, bus_a.out, bus_a.out_valid, exp[47-8*k -: 8]);
      end
    end
    step(0, 0, 2'b00, 8'h00, 5'b0);
    checks++; if (bus_a.out !== 8'h20 || bus_a.out_valid !== 1'b0) begin failures++; $display("FAIL begin_idle act=%h/%b exp=20/0", bus_a.out, bus_a.out_valid); end
    checks++; if (bus_a.depth !== 5'd1 || bus_a.balanced !== 1'b0) begin failures++; $display("FAIL begin_depth act=%0d/%b exp=1/0", bus_a.depth, bus_a.balanced); end
    checks++; if (bus_a.balanced !== (ck_dep == 0 && !ck_uf)) begin failures++; $display("FAIL begin_checker act=%b exp=%b", bus_a.balanced, (ck_dep == 0 && !ck_uf)); end
  endtask

  task automatic test_mixed_case();
    logic [79:0] exp = "bEgIN End ";
    bit          rdy;
    step(1, 0, 2'b00, 8'h00, 5'b0);
    for (int c = 0; c < 16; c++) begin
      step(0, (c <= 6), (c == 0) ? 2'b00 : 2'b01, 8'h00, (c == 0) ? 5'b11010 : 5'b00001);
      rdy = (c == 0 || c == 6 || c >= 10);
      checks++; if (obs_ready_a !== rdy) begin failures++; $display("FAIL mixed_ready c=%0d act=%b exp=%b", c, obs_ready_a, rdy); end
      checks++;
      if (c >= 1 && c <= 10) begin
        if (bus_a.out !== exp[79-8*(c-1) -: 8] || bus_a.out_valid !== 1'b1) begin
          failures++; $display("FAIL mixed_byte c=%0d act=%h/%b exp=%h/1", c, bus_a.out, bus_a.out_valid, exp[79-8*(c-1) -: 8]);
        end
      end else if (bus_a.out_valid !== 1'b0) begin
        failures++; $display("FAIL mixed_idle c=%0d act=%b exp=0", c, bus_a.out_valid);
      end
    end
    checks++; if (bus_a.depth !== 5'd0 || bus_a.balanced !== 1'b1) begin failures++; $display("FAIL mixed_final act=%0d/%b exp=0/1", bus_a.depth, bus_a.balanced); end
    checks++; if (bus_a.balanced !== (ck_dep == 0 && !ck_uf)) begin failures++; $display("FAIL mixed_checker act=%b exp=%b", bus_a.balanced, (ck_dep == 0 && !ck_uf)); end
  endtask

  task automatic test_underflow();
    logic [31:0] got = '0;
    int          n = 0;
    step(1, 0, 2'b00, 8'h00, 5'b0);
    step(0, 1, 2'b01, 8'h00, 5'b0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 2'b00, 8'h00, 5'b0);
      if (bus_a.out_valid === 1'b1) begin got = {got[23:0], bus_a.out}; n++; end
    end
    checks++; if (got !== 32'h656E6420 || n != 4) begin failures++; $display("FAIL uf_stream act=%h/%0d exp=656e6420/4", got, n); end
    checks++; if (bus_a.underflow !== 1'b1 || bus_a.depth !== 5'd0 || bus_a.balanced !== 1'b0) begin failures++; $display("FAIL uf_flag act=%b/%0d/%b exp=1/0/0", bus_a.underflow, bus_a.depth, bus_a.balanced); end
    step(0, 1, 2'b00, 8'h00, 5'b0);
    for (int k = 0; k < 6; k++) step(0, 0, 2'b00, 8'h00, 5'b0);
    checks++; if (bus_a.depth !== 5'd1 || bus_a.balanced !== 1'b0) begin failures++; $display("FAIL uf_begin act=%0d/%b exp=1/0", bus_a.depth, bus_a.balanced); end
    step(0, 1, 2'b01, 8'h00, 5'b0);
    for (int k = 0; k < 5; k++) step(0, 0, 2'b00, 8'h00, 5'b0);
    checks++; if (bus_a.depth !== 5'd0 || bus_a.balanced !== 1'b0 || bus_a.underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky act=%0d/%b/%b exp=0/0/1", bus_a.depth, bus_a.balanced, bus_a.underflow); end
    checks++; if (bus_a.balanced !== (ck_dep == 0 && !ck_uf)) begin failures++; $display("FAIL uf_checker act=%b exp=%b", bus_a.balanced, (ck_dep == 0 && !ck_uf)); end
  endtask

  task automatic test_char_nop();
    logic [7:0] got[$];
    step(1, 0, 2'b00, 8'h00, 5'b0);
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       step(0, 1, 2'b10, 8'h61, 5'b11111);
        1:       step(0, 1, 2'b11, 8'h00, 5'b11111);
        2:       step(0, 1, 2'b10, 8'h20, 5'b11111);
        default: step(0, 0, 2'b00, 8'h00, 5'b0);
      endcase
      if (bus_a.out_valid === 1'b1) got.push_back(bus_a.out);
    end
    checks++; if (got.size() != 2) begin failures++; $display("FAIL char_count act=%0d exp=2", got.size()); end
    checks++; if (got.size() == 2 && (got[0] !== 8'h61 || got[1] !== 8'h20)) begin failures++; $display("FAIL char_bytes act=%h,%h exp=61,20", got[0], got[1]); end
    checks++; if (bus_a.depth !== 5'd0 || bus_a.balanced !== 1'b1) begin failures++; $display("FAIL char_depth act=%0d/%b exp=0/1", bus_a.depth, bus_a.balanced); end
  endtask

  task automatic test_reset_mid_word();
    step(1, 0, 2'b00, 8'h00, 5'b0);
    step(0, 1, 2'b00, 8'h00, 5'b0);
    for (int k = 0; k < 3; k++) step(0, 0, 2'b00, 8'h00, 5'b0);
    checks++; if (bus_a.out !== 8'h67 || bus_a.out_valid !== 1'b1) begin failures++; $display("FAIL mid_third act=%h/%b exp=67/1", bus_a.out, bus_a.out_valid); end
    step(1, 0, 2'b00, 8'h00, 5'b0);
    checks++; if (bus_a.out !== 8'h20 || bus_a.out_valid !== 1'b0 || bus_a.depth !== 5'd0) begin failures++; $display("FAIL mid_abort act=%h/%b/%0d exp=20/0/0", bus_a.out, bus_a.out_valid, bus_a.depth); end
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 2'b00, 8'h00, 5'b0);
      if (k == 0) begin
        checks++; if (obs_ready_a !== 1'b1) begin failures++; $display("FAIL mid_ready act=%b exp=1", obs_ready_a); end
      end
      checks++; if (bus_a.out_valid !== 1'b0) begin failures++; $display("FAIL mid_leftover k=%0d act=%b exp=0", k, bus_a.out_valid); end
    end
  endtask

  task automatic test_overflow();
    int n = 0;
    step(1, 0, 2'b00, 8'h00, 5'b0);
    for (int c = 0; c < 40 && n < 4; c++) begin
      step(0, 1, 2'b00, 8'h00, 5'b0);
      if (m_accept) begin
        n++;
        if (n == 3) begin
          checks++; if (bus_b.depth !== 2'd3 || bus_b.overflow !== 1'b0) begin failures++; $display("FAIL ovf_third act=%0d/%b exp=3/0", bus_b.depth, bus_b.overflow); end
        end
        if (n == 4) begin
          checks++; if (bus_b.depth !== 2'd3 || bus_b.overflow !== 1'b1) begin failures++; $display("FAIL ovf_fourth act=%0d/%b exp=3/1", bus_b.depth, bus_b.overflow); end
          checks++; if (bus_a.depth !== 5'd4 || bus_a.overflow !== 1'b0) begin failures++; $display("FAIL ovf_wide act=%0d/%b exp=4/0", bus_a.depth, bus_a.overflow); end
        end
      end
    end
    checks++; if (n != 4) begin failures++; $display("FAIL ovf_timeout accepts=%0d exp=4", n); end
  endtask

  task automatic test_random();
    bit rst;
    step(1, 0, 2'b00, 8'h00, 5'b0);
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      step(rst, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom), 5'($urandom));
      checks++; if (obs_ready_a !== m_ready || obs_ready_b !== m_ready) begin failures++; $display("FAIL rnd_ready c=%0d act=%b/%b exp=%b", c, obs_ready_a, obs_ready_b, m_ready); end
      checks++; if (bus_a.out !== exp_out || bus_a.out_valid !== exp_valid) begin failures++; $display("FAIL rnd_out_a c=%0d act=%h/%b exp=%h/%b", c, bus_a.out, bus_a.out_valid, exp_out, exp_valid); end
      checks++; if (bus_b.out !== exp_out || bus_b.out_valid !== exp_valid) begin failures++; $display("FAIL rnd_out_b c=%0d act=%h/%b exp=%h/%b", c, bus_b.out, bus_b.out_valid, exp_out, exp_valid); end
      checks++; if (bus_a.depth !== 5'(dep_a) || bus_b.depth !== 2'(dep_b)) begin failures++; $display("FAIL rnd_depth c=%0d act=%0d/%0d exp=%0d/%0d", c, bus_a.depth, bus_b.depth, dep_a, dep_b); end
      checks++; if (bus_a.underflow !== uf_a || bus_a.overflow !== of_a) begin failures++; $display("FAIL rnd_flags_a c=%0d act=%b%b exp=%b%b", c, bus_a.underflow, bus_a.overflow, uf_a, of_a); end
      checks++; if (bus_b.underflow !== uf_b || bus_b.overflow !== of_b) begin failures++; $display("FAIL rnd_flags_b c=%0d act=%b%b exp=%b%b", c, bus_b.underflow, bus_b.overflow, uf_b, of_b); end
      checks++; if (bus_a.balanced !== (dep_a == 0 && !uf_a) || bus_b.balanced !== (dep_b == 0 && !uf_b)) begin failures++; $display("FAIL rnd_balanced c=%0d act=%b/%b", c, bus_a.balanced, bus_b.balanced); end
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_char = 8'h00; cmd_upper = 5'b0;
    test_reset();
    test_single_begin();
    test_mixed_case();
    test_underflow();
    test_char_nop();
    test_reset_mid_word();
    test_overflow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/block_stream_gen.md
BLOCK_STREAM_GEN -- requirements
Module: block_stream_gen

Interface
REQ-001 Parameter DEPTH_W, default 5: nesting-depth counter width.
REQ-002 Signal clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Signal reset  input  1  synchronous, active-high reset.
REQ-004 Signal cmd_valid  input  1  command present.
REQ-005 Signal cmd_ready  output  1  command accepted when high with cmd_valid on a rising edge.
REQ-006 Signal cmd_op  input  2  opcode:
- 00 BEGIN
- 01 END
- 10 CHAR
- 11 NOP
REQ-007 Signal cmd_char  input  8  literal ASCII byte, used by CHAR only.
REQ-008 Signal cmd_upper  input  5  per-letter uppercase mask; bit i uppercases keyword letter i (bit 0 = first letter).
REQ-009 Signal out  output  8  ASCII character stream, one byte per cycle; feeds a block checker's 8-bit in port directly.
REQ-010 Signal out_valid  output  1  out carries an emitted character this cycle.
REQ-011 Signal depth  output  DEPTH_W  current open-block count.
REQ-012 Signal balanced  output  1  high when depth==0 and underflow==0.
REQ-013 Signal underflow  output  1  sticky; END was issued at depth 0.
REQ-014 Signal overflow  output  1  sticky; BEGIN was issued at maximum depth.

Function
REQ-015 FSM states: IDLE, EMIT; registered byte index idx, 0..5.
REQ-016 cmd_ready SHALL be high when:
- state==IDLE, or
- state==EMIT and the current byte is the last of its command.
This gives back-to-back commands with no gap cycle.
REQ-017 On accept, the block SHALL latch cmd_op, cmd_char and cmd_upper, set idx=0, and enter EMIT, except for NOP.
REQ-018 NOP SHALL be accepted with no output, no depth change, and no state change.
REQ-019 Latency: the first byte SHALL appear on out with out_valid=1 exactly one cycle after the accept edge.
REQ-020 Each command SHALL emit the following bytes, one per cycle, contiguously:
- BEGIN: "begin " (6 bytes).
- END: "end " (4 bytes).
- CHAR: cmd_char (1 byte).
REQ-021 For keyword letter i, if cmd_upper[i]=1, that byte SHALL be lowercase minus 8'h20.
REQ-022 cmd_upper SHALL NOT affect the trailing space or CHAR bytes; mask bits beyond the keyword length SHALL be ignored.
REQ-023 When no byte is being emitted, out SHALL be 8'h20 (space) and out_valid SHALL be 0.
REQ-024 After the last byte, the block SHALL return to IDLE unless a new command was accepted on that same edge, in which case it SHALL restart EMIT with idx=0.
REQ-025 Depth SHALL update on the accept edge:
- BEGIN: +1.
- END: -1.
REQ-026 END at depth 0 SHALL set underflow and leave depth at 0.
REQ-027 BEGIN at depth 2^DEPTH_W-1 SHALL set overflow and leave depth unchanged.
REQ-028 underflow and overflow SHALL clear only on reset; bytes are still emitted in both cases.
REQ-029 CHAR SHALL never alter depth, even if the literal spells a keyword across multiple commands.

Reset
REQ-030 While reset=1 at a rising edge, the block SHALL:
- set state=IDLE, idx=0;
- set out=8'h20 and out_valid=0;
- clear depth, underflow and overflow;
- ignore cmd_valid.
REQ-031 Reset SHALL win over every simultaneous event.
REQ-032 Reset mid-EMIT SHALL abort the word immediately; the remaining bytes SHALL NOT be emitted.
REQ-033 The cycle after reset deasserts SHALL show cmd_ready=1 and balanced=1.

Structure
REQ-034 Shared package block_gen_pkg SHALL hold:
- opcode constants;
- ASCII constants: space, 8'h20 case offset;
- FSM state encoding;
- keyword lengths (6, 4, 1).
REQ-035 Combinational sub-module block_char_rom(op, idx, mask, lit) -> char SHALL produce the byte for each position; FSM, counters and flags stay in block_stream_gen.
REQ-036 out and out_valid SHALL be registered outputs; cmd_ready SHALL be combinational from state/idx.

Verification
REQ-037 Scenario, single BEGIN:
- Stimulus: reset, then BEGIN with mask 5'b00000.
- Required: out = 62,65,67,69,6E,20 on 6 consecutive cycles starting the cycle after accept, depth=1, balanced=0.
REQ-038 Scenario, mixed case:
- Stimulus: BEGIN with mask 5'b11010, then END with mask 5'b00001, back-to-back.
- Required:
  - stream "bEgIN End " with no idle cycle between words;
  - cmd_ready high on cycles 6 and 10;
  - final depth=0, balanced=1.
REQ-039 Scenario, underflow:
- Stimulus: after reset, END, then BEGIN.
- Required:
  - "end " emitted, underflow=1, depth=0;
  - after BEGIN: depth=1, balanced=0;
  - a further END gives depth 0 but balanced stays 0.
REQ-040 Scenario, CHAR and NOP:
- Stimulus: CHAR 8'h61, NOP, CHAR 8'h20.
- Required: out 61 then 20 on consecutive valid cycles; NOP produces no byte; depth unchanged.
REQ-041 Scenario, reset mid-word:
- Stimulus: reset asserted during the 3rd byte of BEGIN.
- Required: next cycle out=20, out_valid=0, depth=0, cmd_ready=1 after release.
REQ-042 Scenario, overflow (DEPTH_W=2):
- Stimulus: 4 BEGINs.
- Required: depth saturates at 3 and overflow=1 after the 4th accept.
- Cross-check: loop the stream into the block checker and confirm its result matches balanced in every scenario.
